// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the fetch unit, the load/store buffer,
// the external byte-wide RAM/IO port and the memory controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;
  logic              if_to_mc_enable;
  logic [ADDR_W-1:0] if_to_mc_pc;
  logic              mc_to_if_done;
  logic [31:0]       mc_to_if_result;
  logic              lsb_to_mc_enable;
  logic              lsb_to_mc_wr;
  logic [ADDR_W-1:0] lsb_to_mc_addr;
  logic [1:0]        lsb_to_mc_size;
  logic [31:0]       lsb_to_mc_data;
  logic              mc_to_lsb_done;
  logic [31:0]       mc_to_lsb_result;
  logic              rob_to_mc_rollback;

  modport slave (
    input  mem_din, io_buffer_full, if_to_mc_enable, if_to_mc_pc,
           lsb_to_mc_enable, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_size,
           lsb_to_mc_data, rob_to_mc_rollback,
    output mem_dout, mem_a, mem_wr, mc_to_if_done, mc_to_if_result,
           mc_to_lsb_done, mc_to_lsb_result
  );

  modport master (
    output mem_din, io_buffer_full, if_to_mc_enable, if_to_mc_pc,
           lsb_to_mc_enable, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_size,
           lsb_to_mc_data, rob_to_mc_rollback,
    input  mem_dout, mem_a, mem_wr, mc_to_if_done, mc_to_if_result,
           mc_to_lsb_done, mc_to_lsb_result
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: 32-bit fetches and 1/2/4-byte loads/stores on one RAM port.
// Optional macro MC_IO_STALL_EN: hold IO-region store bytes while io_buffer_full is high.
module mem_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_IF_READ, S_LS_READ, S_LS_WRITE} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [2:0]        r_len, w_len_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_mem_a, w_mem_a_nxt;
  logic [31:0]       r_data, w_data_nxt;
  logic [31:0]       r_buf, w_buf_nxt;
  logic [31:0]       r_if_res, w_if_res_nxt;
  logic [31:0]       r_lsb_res, w_lsb_res_nxt;
  logic [7:0]        r_mem_dout, w_mem_dout_nxt;
  logic              r_mem_wr, w_mem_wr_nxt;
  logic              r_if_done, w_if_done_nxt;
  logic              r_lsb_done, w_lsb_done_nxt;
  logic              w_stall;
  logic              w_recover;
  logic [2:0]        w_req_len;
  logic [1:0]        w_cidx;

`ifdef MC_IO_STALL_EN
  assign w_stall = (r_state == S_LS_WRITE) && (r_mem_a[17:16] == IO_HI) && bus.io_buffer_full;
`else
  logic w_unused;
  assign w_stall  = 1'b0;
  assign w_unused = ^{bus.io_buffer_full, IO_HI};
`endif

  // Requesters drop enable only after seeing done, so the done cycle must not accept.
  assign w_recover = r_if_done || r_lsb_done;
  assign w_req_len = (bus.lsb_to_mc_size == 2'd0) ? 3'd1 :
                     (bus.lsb_to_mc_size == 2'd1) ? 3'd2 : 3'd4;
  // In cycle k of a read, mem_din carries byte k-2.
  assign w_cidx    = r_cnt[1:0] - 2'd2;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_len_nxt      = r_len;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_buf_nxt      = r_buf;
    w_mem_a_nxt    = r_mem_a;
    w_mem_dout_nxt = r_mem_dout;
    w_mem_wr_nxt   = r_mem_wr;
    w_if_res_nxt   = r_if_res;
    w_lsb_res_nxt  = r_lsb_res;
    w_if_done_nxt  = 1'b0;
    w_lsb_done_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_recover) begin
          if (bus.lsb_to_mc_enable && bus.lsb_to_mc_wr) begin
            w_state_nxt    = S_LS_WRITE;
            w_addr_nxt     = bus.lsb_to_mc_addr;
            w_data_nxt     = bus.lsb_to_mc_data;
            w_len_nxt      = w_req_len;
            w_mem_a_nxt    = bus.lsb_to_mc_addr;
            w_mem_dout_nxt = bus.lsb_to_mc_data[7:0];
            w_mem_wr_nxt   = 1'b1;
            w_cnt_nxt      = 3'd1;
          end else if (!bus.rob_to_mc_rollback && bus.lsb_to_mc_enable) begin
            w_state_nxt  = S_LS_READ;
            w_addr_nxt   = bus.lsb_to_mc_addr;
            w_len_nxt    = w_req_len;
            w_mem_a_nxt  = bus.lsb_to_mc_addr;
            w_mem_wr_nxt = 1'b0;
            w_buf_nxt    = '0;
            w_cnt_nxt    = 3'd1;
          end else if (!bus.rob_to_mc_rollback && bus.if_to_mc_enable) begin
            w_state_nxt  = S_IF_READ;
            w_addr_nxt   = bus.if_to_mc_pc;
            w_len_nxt    = 3'd4;
            w_mem_a_nxt  = bus.if_to_mc_pc;
            w_mem_wr_nxt = 1'b0;
            w_buf_nxt    = '0;
            w_cnt_nxt    = 3'd1;
          end
        end
      end
      // Stores are already committed, so rollback does not interrupt them.
      S_LS_WRITE: begin
        if (!w_stall) begin
          if (r_cnt == r_len) begin
            w_state_nxt    = S_IDLE;
            w_mem_wr_nxt   = 1'b0;
            w_cnt_nxt      = 3'd0;
            w_lsb_done_nxt = 1'b1;
          end else begin
            w_mem_a_nxt    = r_addr + ADDR_W'(r_cnt);
            w_mem_dout_nxt = r_data[{r_cnt[1:0], 3'b000} +: 8];
            w_cnt_nxt      = r_cnt + 3'd1;
          end
        end
      end
      default: begin
        if (bus.rob_to_mc_rollback) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          if (r_cnt >= 3'd2) w_buf_nxt[{w_cidx, 3'b000} +: 8] = bus.mem_din;
          if (r_cnt < r_len) w_mem_a_nxt = r_addr + ADDR_W'(r_cnt);
          if (r_cnt == r_len + 3'd1) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
            if (r_state == S_IF_READ) begin
              w_if_done_nxt = 1'b1;
              w_if_res_nxt  = w_buf_nxt;
            end else begin
              w_lsb_done_nxt = 1'b1;
              w_lsb_res_nxt  = w_buf_nxt;
            end
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_buf      <= '0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_mem_wr   <= 1'b0;
      r_if_res   <= '0;
      r_lsb_res  <= '0;
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_buf      <= w_buf_nxt;
      r_mem_a    <= w_mem_a_nxt;
      r_mem_dout <= w_mem_dout_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_if_res   <= w_if_res_nxt;
      r_lsb_res  <= w_lsb_res_nxt;
      r_if_done  <= w_if_done_nxt;
      r_lsb_done <= w_lsb_done_nxt;
    end
  end

  assign bus.mem_a            = r_mem_a;
  assign bus.mem_dout         = r_mem_dout;
  assign bus.mem_wr           = r_mem_wr && rdy && !w_stall;
  assign bus.mc_to_if_done    = r_if_done;
  assign bus.mc_to_if_result  = r_if_res;
  assign bus.mc_to_lsb_done   = r_lsb_done;
  assign bus.mc_to_lsb_result = r_lsb_res;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model plus per-requester expected-result queues.
`timescale 1ns/1ps
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, rdy;
  always #5 clk = ~clk;

  mem_ctrl_if bus();
  mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus.slave));

`ifdef MC_IO_STALL_EN
  localparam int IO_STALL = 3;
`else
  localparam int IO_STALL = 0;
`endif

  // RAM returns the byte for the address presented in the previous cycle.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[15:0]];
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
    int          cyc;
    bit          chkv;
  } exp_t;

  exp_t q_if[$];
  exp_t q_lsb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_ifd = 0;
  int n_lsbd = 0;
  logic        wr_log [0:31];
  logic [31:0] a_log  [0:31];
  logic [7:0]  d_log  [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input string tag, input logic [31:0] v, input int c);
    exp_t e;
    e.tag = tag; e.val = v; e.cyc = c; e.chkv = 1'b1;
    q_if.push_back(e);
  endtask

  task automatic push_lsb(input string tag, input logic [31:0] v, input int c, input bit cv);
    exp_t e;
    e.tag = tag; e.val = v; e.cyc = c; e.chkv = cv;
    q_lsb.push_back(e);
  endtask

  task automatic req_if(input logic [31:0] pc);
    bus.if_to_mc_enable = 1'b1;
    bus.if_to_mc_pc     = pc;
  endtask

  task automatic req_lsb(input bit wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    bus.lsb_to_mc_enable = 1'b1;
    bus.lsb_to_mc_wr     = wr;
    bus.lsb_to_mc_addr   = a;
    bus.lsb_to_mc_size   = sz;
    bus.lsb_to_mc_data   = d;
  endtask

  // Runs max cycles from the request cycle (n = 0); requesters drop enable the cycle after done.
  task automatic run(input int max, input int rb_cyc, input bit rb_drop,
                     input int rdy_lo, input int rdy_n, input int io_lo, input int io_n);
    bit drop_if, drop_lsb;
    exp_t e;
    drop_if = 1'b0;
    drop_lsb = 1'b0;
    for (int n = 0; n < max; n++) begin
      if (n > 0) begin
        next();
        if (drop_if)  begin bus.if_to_mc_enable  = 1'b0; drop_if  = 1'b0; end
        if (drop_lsb) begin bus.lsb_to_mc_enable = 1'b0; drop_lsb = 1'b0; end
      end
      bus.rob_to_mc_rollback = (n == rb_cyc);
      if (n == rb_cyc && rb_drop) begin
        bus.if_to_mc_enable  = 1'b0;
        bus.lsb_to_mc_enable = 1'b0;
      end
      rdy = !(n >= rdy_lo && n < rdy_lo + rdy_n);
      bus.io_buffer_full = (n >= io_lo && n < io_lo + io_n);
      @(negedge clk);
      if (n < 32) begin
        wr_log[n] = bus.mem_wr;
        a_log[n]  = bus.mem_a;
        d_log[n]  = bus.mem_dout;
      end
      if (bus.mc_to_if_done) begin
        n_ifd++;
        drop_if = 1'b1;
        if (q_if.size() == 0) chk("if_unexpected_done", 32'd1, 32'd0);
        else begin
          e = q_if.pop_front();
          chk({e.tag, "_cyc"}, n, e.cyc);
          chk({e.tag, "_res"}, bus.mc_to_if_result, e.val);
        end
      end
      if (bus.mc_to_lsb_done) begin
        n_lsbd++;
        drop_lsb = 1'b1;
        if (q_lsb.size() == 0) chk("lsb_unexpected_done", 32'd1, 32'd0);
        else begin
          e = q_lsb.pop_front();
          chk({e.tag, "_cyc"}, n, e.cyc);
          if (e.chkv) chk({e.tag, "_res"}, bus.mc_to_lsb_result, e.val);
        end
      end
    end
    while (q_if.size() > 0) begin
      e = q_if.pop_front();
      chk({e.tag, "_timeout"}, 32'd0, 32'd1);
    end
    while (q_lsb.size() > 0) begin
      e = q_lsb.pop_front();
      chk({e.tag, "_timeout"}, 32'd0, 32'd1);
    end
    bus.if_to_mc_enable    = 1'b0;
    bus.lsb_to_mc_enable   = 1'b0;
    bus.rob_to_mc_rollback = 1'b0;
    bus.io_buffer_full     = 1'b0;
    rdy = 1'b1;
  endtask

  int ifd0;

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.io_buffer_full     = 1'b0;
    bus.if_to_mc_enable    = 1'b0;
    bus.if_to_mc_pc        = '0;
    bus.lsb_to_mc_enable   = 1'b0;
    bus.lsb_to_mc_wr       = 1'b0;
    bus.lsb_to_mc_addr     = '0;
    bus.lsb_to_mc_size     = '0;
    bus.lsb_to_mc_data     = '0;
    bus.rob_to_mc_rollback = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
    chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'h0);
    chk("rst_if_done", {31'd0, bus.mc_to_if_done}, 32'h0);
    chk("rst_lsb_done", {31'd0, bus.mc_to_lsb_done}, 32'h0);
    chk("rst_if_res", bus.mc_to_if_result, 32'h0);
    chk("rst_lsb_res", bus.mc_to_lsb_result, 32'h0);

    // Place the instruction word 0x00000513 (bytes 13,05,00,00) at 0x1000.
    next(); req_lsb(1'b1, 32'h1000, 2'd2, 32'h0000_0513); push_lsb("st_ins", 32'h0, 5, 1'b0);
    run(8, -1, 1'b0, -1, 0, -1, 0);

    // Fetch: done in cycle 6; a refetch during recovery would give an unexpected done.
    next(); req_if(32'h1000); push_if("fetch", 32'h0000_0513, 6);
    run(16, -1, 1'b0, -1, 0, -1, 0);
    chk("fetch_a1", a_log[1], 32'h1000);
    chk("fetch_a4", a_log[4], 32'h1003);
    chk("fetch_wr2", {31'd0, wr_log[2]}, 32'd0);
    chk("fetch_pulse7", {31'd0, bus.mc_to_if_done}, 32'd0);

    // 2-byte store of 0xDEADBEEF at 0x20.
    next(); req_lsb(1'b1, 32'h20, 2'd1, 32'hDEAD_BEEF); push_lsb("st2", 32'h0, 3, 1'b0);
    run(8, -1, 1'b0, -1, 0, -1, 0);
    chk("st2_wr1", {31'd0, wr_log[1]}, 32'd1);
    chk("st2_wr2", {31'd0, wr_log[2]}, 32'd1);
    chk("st2_wr3", {31'd0, wr_log[3]}, 32'd0);
    chk("st2_a1", a_log[1], 32'h20);
    chk("st2_a2", a_log[2], 32'h21);
    chk("st2_d1", {24'd0, d_log[1]}, 32'hEF);
    chk("st2_d2", {24'd0, d_log[2]}, 32'hBE);

    next(); req_lsb(1'b0, 32'h20, 2'd1, 32'h0); push_lsb("ld2", 32'h0000_BEEF, 4, 1'b1);
    run(8, -1, 1'b0, -1, 0, -1, 0);
    next(); req_lsb(1'b0, 32'h21, 2'd0, 32'h0); push_lsb("ld1", 32'h0000_00BE, 3, 1'b1);
    run(8, -1, 1'b0, -1, 0, -1, 0);
    next(); req_lsb(1'b0, 32'h1000, 2'd3, 32'h0); push_lsb("ld_sz3", 32'h0000_0513, 6, 1'b1);
    run(10, -1, 1'b0, -1, 0, -1, 0);

    // Arbitration: LSB first, IF accepted after the recovery cycle.
    next(); req_if(32'h1000); req_lsb(1'b0, 32'h20, 2'd1, 32'h0);
    push_lsb("arb_ld", 32'h0000_BEEF, 4, 1'b1); push_if("arb_if", 32'h0000_0513, 11);
    run(16, -1, 1'b0, -1, 0, -1, 0);

    // Rollback in cycle 3 of a fetch aborts it.
    ifd0 = n_ifd;
    next(); req_if(32'h1000);
    run(16, 3, 1'b1, -1, 0, -1, 0);
    chk("rb_fetch_nodone", n_ifd - ifd0, 32'd0);
    next(); req_if(32'h1000); push_if("fetch_after_rb", 32'h0000_0513, 6);
    run(10, -1, 1'b0, -1, 0, -1, 0);

    // Rollback while idle: load delayed one cycle, store still accepted.
    next(); req_lsb(1'b0, 32'h20, 2'd1, 32'h0); push_lsb("rbidle_ld", 32'h0000_BEEF, 5, 1'b1);
    run(10, 0, 1'b0, -1, 0, -1, 0);
    next(); req_lsb(1'b1, 32'h70, 2'd0, 32'h0000_005A); push_lsb("rbidle_st", 32'h0, 2, 1'b0);
    run(8, 0, 1'b0, -1, 0, -1, 0);
    next(); req_lsb(1'b0, 32'h70, 2'd0, 32'h0); push_lsb("rbidle_chk", 32'h0000_005A, 3, 1'b1);
    run(8, -1, 1'b0, -1, 0, -1, 0);

    // Rollback during a 4-byte store does not stop it.
    next(); req_lsb(1'b1, 32'h60, 2'd2, 32'hA1B2_C3D4); push_lsb("rb_st4", 32'h0, 5, 1'b0);
    run(8, 2, 1'b0, -1, 0, -1, 0);
    next(); req_lsb(1'b0, 32'h60, 2'd2, 32'h0); push_lsb("rb_st4_chk", 32'hA1B2_C3D4, 6, 1'b1);
    run(10, -1, 1'b0, -1, 0, -1, 0);

    // rdy low for 2 cycles of a fetch, then 1 cycle of a store.
    next(); req_if(32'h1000); push_if("rdy_fetch", 32'h0000_0513, 8);
    run(14, -1, 1'b0, 1, 2, -1, 0);
    next(); req_lsb(1'b1, 32'h40, 2'd2, 32'h1122_3344); push_lsb("rdy_st4", 32'h0, 6, 1'b0);
    run(10, -1, 1'b0, 2, 1, -1, 0);
    chk("rdy_st_wr2", {31'd0, wr_log[2]}, 32'd0);
    chk("rdy_st_wr3", {31'd0, wr_log[3]}, 32'd1);
    chk("rdy_st_a3", a_log[3], 32'h41);
    chk("rdy_st_d3", {24'd0, d_log[3]}, 32'h33);
    next(); req_lsb(1'b0, 32'h40, 2'd2, 32'h0); push_lsb("rdy_st_chk", 32'h1122_3344, 6, 1'b1);
    run(10, -1, 1'b0, -1, 0, -1, 0);

    // IO-region byte store with the IO buffer full in cycles 1..3.
    next(); req_lsb(1'b1, 32'h0003_0000, 2'd0, 32'h0000_0077); push_lsb("io_st", 32'h0, 2 + IO_STALL, 1'b0);
    run(10, -1, 1'b0, -1, 0, 1, 3);
    chk("io_a1", a_log[1], 32'h0003_0000);
    chk("io_wr1", {31'd0, wr_log[1]}, (IO_STALL == 0) ? 32'd1 : 32'd0);
    chk("io_wr3", {31'd0, wr_log[3]}, 32'd0);
    chk("io_wr4", {31'd0, wr_log[4]}, (IO_STALL == 0) ? 32'd0 : 32'd1);

    // Reset in the middle of a store.
    next(); req_lsb(1'b1, 32'h50, 2'd2, 32'hCAFE_F00D);
    next();
    next();
    rst = 1'b1;
    bus.lsb_to_mc_enable = 1'b0;
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_mem_a", bus.mem_a, 32'h0);
    chk("mrst_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
    chk("mrst_mem_dout", {24'd0, bus.mem_dout}, 32'h0);
    chk("mrst_lsb_done", {31'd0, bus.mc_to_lsb_done}, 32'h0);
    chk("mrst_if_res", bus.mc_to_if_result, 32'h0);
    chk("mrst_lsb_res", bus.mc_to_lsb_result, 32'h0);
    next(); req_if(32'h1000); push_if("post_rst", 32'h0000_0513, 6);
    run(10, -1, 1'b0, -1, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
